btb_update_queue: RTL and testbench
===================================

# btb_update_queue

Write-side companion of the branch target buffer. It accepts resolved-branch reports from the execute stage and keeps only those that need a BTB change: a taken branch that missed or mispredicted its target. It buffers them in a small FIFO and drains them one per cycle into the BTB load port (`new_PC`/`new_target`/`new_btype`/`load`) whenever fetch grants a free slot.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the saturating update counter.
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `res_valid` input 1: resolution report valid this cycle.
- `res_ready` output 1: queue can accept a report; equals `count != DEPTH`.
- `res_PC` input 29: fetch-block PC of resolved branch (BTB tag).
- `res_target` input 30: resolved target (fetch PC + block index).
- `res_btype` input 2: branch type (ret/jmp encoding, same as BTB).
- `res_taken` input 1: branch resolved taken.
- `res_pred_hit` input 1: BTB hit at fetch for this branch.
- `res_pred_target` input 30: target the BTB supplied at fetch.
- `drain_en` input 1: fetch grants the BTB write slot this cycle.
- `flush` input 1: discard all queued, undrained updates.
- `new_PC` output 29: BTB write tag (head entry).
- `new_target` output 30: BTB write target.
- `new_btype` output 2: BTB write type.
- `load` output 1: BTB write strobe.
- `upd_count` output CNT_W: number of BTB writes issued, saturating.

## Operation
- Need-update: `need = res_taken & (~res_pred_hit | (res_pred_target != res_target))`. A not-taken report or a correct hit needs no update.
- Accept: `res_valid & res_ready`. The report is enqueued only when `need`; an accepted report with `need=0` is consumed and dropped.
- FIFO state: head pointer, tail pointer, and `count`. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Drain: `load = (count != 0) & drain_en & ~flush`. `new_*` always show the head entry, and are all-zero when empty. Each cycle with `load=1` pops exactly one entry.
- Simultaneous enqueue and pop: `count` is unchanged and both pointers advance. When full, `res_ready=0` even if a pop occurs in the same cycle; there is no ready-through.
- Flush: pointers and `count` go to 0 at the edge. `load` is forced 0 in the flush cycle. A report presented in the flush cycle is dropped, even if `res_ready=1`.
- `upd_count` increments on every `load=1` cycle and holds at all-ones.
- Report fields are captured into the entry at the accept edge. Later changes to the inputs do not affect the queued data.

## Timing
- Reset values: `res_ready=1`, `load=0`, `new_PC=0`, `new_target=0`, `new_btype=0`, `upd_count=0`, queue empty.
- Latency: a report accepted at edge N into an empty queue has `load=1` in cycle N+1 if `drain_en` is high. There is no same-cycle bypass.
- `load`, `res_ready`, and `new_*` are combinational from registered state plus `drain_en`/`flush`. No combinational path exists from `res_*` to any output.
- Throughput: one accept and one drain per cycle.
- Reset or flush in the middle of a drain: the pending head is discarded and no partial write is issued.

## Configuration
- `BTB_UPD_COALESCE_EN` defined: an accepted `need` report whose `res_PC` equals the tail entry's PC overwrites that entry's target and btype. No new entry is allocated and `count` does not grow.
  - Exception: if that tail entry is the head and is being popped this cycle (`count==1 & load`), the report is enqueued normally.
  - `res_ready` stays `count != DEPTH`.
- Not defined: every `need` report allocates its own entry, so duplicate PCs drain as separate writes in order.

## Test plan
- Reset, then one report (PC=0x100, target=0x2000, taken, pred_hit=0) with `drain_en=1` -> `load=1` one cycle later with `new_PC=0x100`, `new_target=0x2000`; `upd_count=1`.
- Correct prediction (taken, pred_hit=1, pred_target=target) and a not-taken report -> `res_ready` stays 1, no `load` ever, `upd_count=0`.
- Four `need` reports with `drain_en=0` -> `res_ready=0`. A fifth report is held off. Raising `drain_en` -> four loads in order, then `res_ready` returns to 1.
- `count==2` with `flush=1` and `drain_en=1` in the same cycle -> no `load`, queue empty next cycle, `new_*=0`.
- Back-to-back reports with PC=0x40, targets 0x10 then 0x20, `drain_en=0`:
  - with `BTB_UPD_COALESCE_EN` -> one entry, one `load` with `new_target=0x20`;
  - without it -> two loads, 0x10 then 0x20.
- Continuous accept and drain for 20 cycles across pointer wrap -> data order preserved and `count` constant at 1.

Source files
------------

// File: rtl/btb_update_queue.sv
// btb_update_queue: write-side companion of the branch target buffer.
// Filters resolved-branch reports down to those needing a BTB change
// (taken and either missed or mispredicted target), buffers them in a
// small FIFO and drains one per cycle into the BTB load port when fetch
// grants the write slot.
//
// Optional feature macro: BTB_UPD_COALESCE_EN
//   defined   -> a report matching the tail entry's PC overwrites that entry
//   undefined -> every qualifying report allocates its own entry

module btb_update_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [28:0]      res_PC,
    input  logic [29:0]      res_target,
    input  logic [1:0]       res_btype,
    input  logic             res_taken,
    input  logic             res_pred_hit,
    input  logic [29:0]      res_pred_target,
    input  logic             drain_en,
    input  logic             flush,
    output logic [28:0]      new_PC,
    output logic [29:0]      new_target,
    output logic [1:0]       new_btype,
    output logic             load,
    output logic [CNT_W-1:0] upd_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [28:0]      pc_mem  [DEPTH];
    logic [29:0]      tgt_mem [DEPTH];
    logic [1:0]       bt_mem  [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_last;
    logic [PTR_W-1:0] wr_idx;
    logic [CW-1:0]    count_q;

    logic             empty;
    logic             need;
    logic             accept;
    logic             enq;
    logic             coalesce;
    logic             alloc;

    assign empty     = (count_q == '0);
    assign res_ready = (count_q != CW'(DEPTH));
    assign load      = ~empty & drain_en & ~flush;

    assign need   = res_taken & (~res_pred_hit | (res_pred_target != res_target));
    // A report in the flush cycle is consumed but never stored.
    assign accept = res_valid & res_ready & ~flush;
    assign enq    = accept & need;

    assign tail_last = tail_q - PTR_W'(1);

`ifdef BTB_UPD_COALESCE_EN
    // Merge into the youngest entry unless it is the head leaving this cycle.
    assign coalesce = enq & ~empty & (pc_mem[tail_last] == res_PC)
                      & ~((count_q == CW'(1)) & load);
`else
    assign coalesce = 1'b0;
`endif

    assign alloc  = enq & ~coalesce;
    assign wr_idx = coalesce ? tail_last : tail_q;

    // Head entry is presented to the BTB; zeros when nothing is queued.
    always_comb begin
        new_PC     = '0;
        new_target = '0;
        new_btype  = '0;
        if (!empty) begin
            new_PC     = pc_mem[head_q];
            new_target = tgt_mem[head_q];
            new_btype  = bt_mem[head_q];
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue at the edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc)
                tail_q <= tail_q + PTR_W'(1);
            if (load)
                head_q <= head_q + PTR_W'(1);
            case ({alloc, load})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload capture; storage needs no reset since empty masks it.
    always_ff @(posedge clk) begin
        if (alloc || coalesce) begin
            pc_mem[wr_idx]  <= res_PC;
            tgt_mem[wr_idx] <= res_target;
            bt_mem[wr_idx]  <= res_btype;
        end
    end

    // Saturating count of BTB writes issued.
    always_ff @(posedge clk) begin
        if (rst)
            upd_count <= '0;
        else if (load && (upd_count != {CNT_W{1'b1}}))
            upd_count <= upd_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue. A scoreboard queue holds the
// expected BTB writes in order; a monitor pops and compares on every load.
// Honours BTB_UPD_COALESCE_EN when defined for the build.

module tb_btb_update_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [28:0] res_PC;
    logic [29:0] res_target;
    logic [1:0]  res_btype;
    logic        res_taken;
    logic        res_pred_hit;
    logic [29:0] res_pred_target;
    logic        drain_en;
    logic        flush;
    logic [28:0] new_PC;
    logic [29:0] new_target;
    logic [1:0]  new_btype;
    logic        load;
    logic [15:0] upd_count;

    typedef struct packed {
        logic [28:0] pc;
        logic [29:0] tgt;
        logic [1:0]  bt;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    btb_update_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_PC          (res_PC),
        .res_target      (res_target),
        .res_btype       (res_btype),
        .res_taken       (res_taken),
        .res_pred_hit    (res_pred_hit),
        .res_pred_target (res_pred_target),
        .drain_en        (drain_en),
        .flush           (flush),
        .new_PC          (new_PC),
        .new_target      (new_target),
        .new_btype       (new_btype),
        .load            (load),
        .upd_count       (upd_count)
    );

    // Monitor: every BTB write must match the oldest expected entry.
    always @(negedge clk) begin
        ent_t e;
        if (rst === 1'b0 && load === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected got pc=%h tgt=%h bt=%0d required no load",
                         new_PC, new_target, new_btype);
            end else begin
                e = sb.pop_front();
                if ({new_PC, new_target, new_btype} !== e) begin
                    errors++;
                    $display("FAIL load_data got pc=%h tgt=%h bt=%0d required pc=%h tgt=%h bt=%0d",
                             new_PC, new_target, new_btype, e.pc, e.tgt, e.bt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic set_rep(input logic [28:0] pc, input logic [29:0] tgt,
                           input logic [1:0] bt, input logic taken,
                           input logic hit, input logic [29:0] ptgt);
        res_valid       = 1'b1;
        res_PC          = pc;
        res_target      = tgt;
        res_btype       = bt;
        res_taken       = taken;
        res_pred_hit    = hit;
        res_pred_target = ptgt;
    endtask

    // One clock: samples handshake mid-cycle, updates scoreboard at the edge.
    task automatic step(output logic rdy, output logic ld);
        logic ok;
        logic fl;
        ent_t e;
        @(negedge clk);
        rdy = res_ready;
        ld  = load;
        fl  = flush;
        ok  = res_valid && res_ready && !flush && res_taken &&
              (!res_pred_hit || (res_pred_target != res_target));
        e   = {res_PC, res_target, res_btype};
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else if (ok) begin
`ifdef BTB_UPD_COALESCE_EN
            if (sb.size() != 0 && sb[$].pc == e.pc)
                sb[$] = e;
            else
                sb.push_back(e);
`else
            sb.push_back(e);
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        res_valid       = 1'b0;
        res_PC          = '0;
        res_target      = '0;
        res_btype       = '0;
        res_taken       = 1'b0;
        res_pred_hit    = 1'b0;
        res_pred_target = '0;
        drain_en        = 1'b0;
        flush           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drain_en = 1'b1;
        @(negedge clk);
        checks++;
        if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", res_ready); end
        checks++;
        if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %b required 0", load); end
        checks++;
        if ({new_PC, new_target, new_btype} !== '0)
            begin errors++; $display("FAIL reset_new got pc=%h tgt=%h bt=%0d required 0", new_PC, new_target, new_btype); end
        checks++;
        if (upd_count !== 16'd0) begin errors++; $display("FAIL reset_upd got %0d required 0", upd_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic r, l;
        do_reset();
        drain_en = 1'b1;
        set_rep(29'h100, 30'h2000, 2'd1, 1'b1, 1'b0, 30'h0);
        step(r, l);
        checks++;
        if (l !== 1'b0) begin errors++; $display("FAIL single_no_bypass got load=%b required 0", l); end
        res_valid = 1'b0;
        step(r, l);
        checks++;
        if (l !== 1'b1) begin errors++; $display("FAIL single_latency got load=%b required 1", l); end
        step(r, l);
        checks++;
        if (l !== 1'b0) begin errors++; $display("FAIL single_once got load=%b required 0", l); end
        checks++;
        if (upd_count !== 16'd1) begin errors++; $display("FAIL single_upd got %0d required 1", upd_count); end
    endtask

    task automatic test_no_update();
        logic r, l;
        do_reset();
        drain_en = 1'b1;
        set_rep(29'h200, 30'h300, 2'd2, 1'b1, 1'b1, 30'h300);
        step(r, l);
        set_rep(29'h204, 30'h400, 2'd0, 1'b0, 1'b0, 30'h0);
        step(r, l);
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(r, l);
            checks++;
            if (r !== 1'b1 || l !== 1'b0)
                begin errors++; $display("FAIL noupd_cycle%0d got ready=%b load=%b required ready=1 load=0", i, r, l); end
        end
        checks++;
        if (upd_count !== 16'd0) begin errors++; $display("FAIL noupd_upd got %0d required 0", upd_count); end
    endtask

    task automatic test_full();
        logic r, l;
        int   n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_rep(29'h400 + 29'(i), 30'h1000 + 30'(i * 4), 2'(i), 1'b1, 1'b0, 30'h0);
            step(r, l);
            checks++;
            if (r !== 1'b1) begin errors++; $display("FAIL full_fill%0d got ready=%b required 1", i, r); end
        end
        set_rep(29'h500, 30'h5000, 2'd3, 1'b1, 1'b0, 30'h0);
        for (int i = 0; i < 2; i++) begin
            step(r, l);
            checks++;
            if (r !== 1'b0 || l !== 1'b0)
                begin errors++; $display("FAIL full_hold%0d got ready=%b load=%b required ready=0 load=0", i, r, l); end
        end
        drain_en = 1'b1;
        step(r, l);
        checks++;
        if (r !== 1'b0 || l !== 1'b1)
            begin errors++; $display("FAIL full_no_ready_through got ready=%b load=%b required ready=0 load=1", r, l); end
        res_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            step(r, l);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL full_drain got %0d left required 0", sb.size()); end
        step(r, l);
        checks++;
        if (r !== 1'b1 || l !== 1'b0)
            begin errors++; $display("FAIL full_after got ready=%b load=%b required ready=1 load=0", r, l); end
        checks++;
        if (upd_count !== 16'd4) begin errors++; $display("FAIL full_upd got %0d required 4", upd_count); end
    endtask

    task automatic test_flush();
        logic r, l;
        do_reset();
        set_rep(29'h600, 30'h6000, 2'd1, 1'b1, 1'b0, 30'h0);
        step(r, l);
        set_rep(29'h604, 30'h6004, 2'd2, 1'b1, 1'b1, 30'h1);
        step(r, l);
        set_rep(29'h700, 30'h7000, 2'd3, 1'b1, 1'b0, 30'h0);
        flush    = 1'b1;
        drain_en = 1'b1;
        step(r, l);
        checks++;
        if (l !== 1'b0) begin errors++; $display("FAIL flush_load got %b required 0", l); end
        flush     = 1'b0;
        res_valid = 1'b0;
        step(r, l);
        checks++;
        if (r !== 1'b1 || l !== 1'b0)
            begin errors++; $display("FAIL flush_empty got ready=%b load=%b required ready=1 load=0", r, l); end
        checks++;
        if ({new_PC, new_target, new_btype} !== '0)
            begin errors++; $display("FAIL flush_new got pc=%h tgt=%h bt=%0d required 0", new_PC, new_target, new_btype); end
        step(r, l);
        checks++;
        if (upd_count !== 16'd0) begin errors++; $display("FAIL flush_upd got %0d required 0", upd_count); end
    endtask

    task automatic test_coalesce();
        logic r, l;
        int   nl;
        int   exp_n;
`ifdef BTB_UPD_COALESCE_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        do_reset();
        set_rep(29'h40, 30'h10, 2'd1, 1'b1, 1'b0, 30'h0);
        step(r, l);
        set_rep(29'h40, 30'h20, 2'd2, 1'b1, 1'b0, 30'h0);
        step(r, l);
        res_valid = 1'b0;
        drain_en  = 1'b1;
        nl = 0;
        for (int i = 0; i < 5; i++) begin
            step(r, l);
            if (l === 1'b1) nl++;
        end
        checks++;
        if (nl != exp_n) begin errors++; $display("FAIL coalesce_loads got %0d required %0d", nl, exp_n); end
        checks++;
        if (upd_count !== 16'(exp_n)) begin errors++; $display("FAIL coalesce_upd got %0d required %0d", upd_count, exp_n); end
    endtask

    task automatic test_back_to_back();
        logic r, l;
        do_reset();
        drain_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rep(29'h800 + 29'(i), 30'h3000 + 30'(i * 8), 2'(i), 1'b1, 1'b1, 30'h3004 + 30'(i * 8));
            step(r, l);
            checks++;
            if (r !== 1'b1 || l !== (i > 0))
                begin errors++; $display("FAIL b2b_cycle%0d got ready=%b load=%b required ready=1 load=%b", i, r, l, (i > 0)); end
        end
        res_valid = 1'b0;
        step(r, l);
        checks++;
        if (l !== 1'b1) begin errors++; $display("FAIL b2b_last got load=%b required 1", l); end
        step(r, l);
        checks++;
        if (l !== 1'b0) begin errors++; $display("FAIL b2b_idle got load=%b required 0", l); end
        checks++;
        if (upd_count !== 16'd20) begin errors++; $display("FAIL b2b_upd got %0d required 20", upd_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_update();
        test_full();
        test_flush();
        test_coalesce();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
